// File: rtl/guess_engine.sv
// Number-guessing game core: keypad-driven secret/guess entry with sequential A/B scoring.
// One guess/secret digit pair is compared per cycle; the result lands the cycle after the last pair.
`timescale 1ns/1ps
module guess_engine #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned MAX_TRIES = 10,
  localparam int unsigned AW = $clog2(DIGITS + 1),
  localparam int unsigned TW = $clog2(MAX_TRIES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  output logic [4*DIGITS-1:0] entry,
  output logic [AW-1:0]       entry_len,
  output logic [2:0]          phase,
  output logic [AW-1:0]       a_cnt,
  output logic [AW-1:0]       b_cnt,
  output logic                result_valid,
  output logic [TW-1:0]       tries,
  output logic                win,
  output logic                lose,
  output logic [4*DIGITS-1:0] secret_out,
  output logic                key_reject
);
  localparam int unsigned NW = 4 * DIGITS;
  localparam int unsigned IW = $clog2(DIGITS);
  localparam logic [3:0] KeyBack    = 4'd10;
  localparam logic [3:0] KeyEnter   = 4'd11;
  localparam logic [3:0] KeyRestart = 4'd12;

  typedef enum logic [2:0] {
    StSet   = 3'd0,
    StGuess = 3'd1,
    StScore = 3'd2,
    StWin   = 3'd3,
    StLose  = 3'd4
  } phase_e;

  phase_e        phase_q, phase_d;
  logic [NW-1:0] entry_q, entry_d, secret_q, secret_d, guess_q, guess_d;
  logic [AW-1:0] len_q, len_d, acc_a_q, acc_a_d, acc_b_q, acc_b_d, a_q, a_d, b_q, b_d;
  logic [IW-1:0] gi_q, gi_d, sj_q, sj_d;
  logic [TW-1:0] tries_q, tries_d, tries_inc;
  logic          rv_q, rv_d, rej_q, rej_d;
  logic          dup, hit, last_pair, clear_all;
  logic [AW-1:0] a_new, b_new;

  // Only the occupied nibbles count, so a 0 key never matches the zero padding.
  always_comb begin
    dup = 1'b0;
    for (int unsigned n = 0; n < DIGITS; n++) begin
      if (AW'(n) < len_q && entry_q[4*n +: 4] == key_code) dup = 1'b1;
    end
  end

  assign hit       = guess_q[{gi_q, 2'b00} +: 4] == secret_q[{sj_q, 2'b00} +: 4];
  assign last_pair = (gi_q == IW'(DIGITS - 1)) && (sj_q == IW'(DIGITS - 1));
  assign a_new     = acc_a_q + AW'(hit && (gi_q == sj_q));
  assign b_new     = acc_b_q + AW'(hit && (gi_q != sj_q));
  assign tries_inc = (tries_q < TW'(MAX_TRIES)) ? tries_q + TW'(1) : tries_q;
  assign clear_all = key_valid && (key_code == KeyRestart ||
                     (key_code == KeyEnter && (phase_q == StWin || phase_q == StLose)));

  always_comb begin
    phase_d  = phase_q;
    entry_d  = entry_q;
    len_d    = len_q;
    secret_d = secret_q;
    guess_d  = guess_q;
    acc_a_d  = acc_a_q;
    acc_b_d  = acc_b_q;
    gi_d     = gi_q;
    sj_d     = sj_q;
    a_d      = a_q;
    b_d      = b_q;
    tries_d  = tries_q;
    rv_d     = 1'b0;
    rej_d    = 1'b0;
    if (clear_all) begin
      phase_d  = StSet;
      entry_d  = '0;
      len_d    = '0;
      secret_d = '0;
      guess_d  = '0;
      acc_a_d  = '0;
      acc_b_d  = '0;
      gi_d     = '0;
      sj_d     = '0;
      a_d      = '0;
      b_d      = '0;
      tries_d  = '0;
    end else begin
      case (phase_q)
        StSet, StGuess: begin
          if (key_valid) begin
            if (key_code <= 4'd9) begin
              if (len_q == AW'(DIGITS) || dup) begin
                rej_d = 1'b1;
              end else begin
                entry_d = {entry_q[NW-5:0], key_code};
                len_d   = len_q + AW'(1);
              end
            end else if (key_code == KeyBack) begin
              if (len_q == '0) begin
                rej_d = 1'b1;
              end else begin
                entry_d = {4'd0, entry_q[NW-1:4]};
                len_d   = len_q - AW'(1);
              end
            end else if (key_code == KeyEnter) begin
              if (len_q != AW'(DIGITS)) begin
                rej_d = 1'b1;
              end else if (phase_q == StSet) begin
                secret_d = entry_q;
                entry_d  = '0;
                len_d    = '0;
                tries_d  = '0;
                a_d      = '0;
                b_d      = '0;
                phase_d  = StGuess;
              end else begin
                guess_d = entry_q;
                acc_a_d = '0;
                acc_b_d = '0;
                gi_d    = '0;
                sj_d    = '0;
                phase_d = StScore;
              end
            end else begin
              rej_d = 1'b1;
            end
          end
        end
        StScore: begin
          rej_d = key_valid;
          // The last pair folds straight into the published result.
          if (last_pair) begin
            a_d     = a_new;
            b_d     = b_new;
            rv_d    = 1'b1;
            tries_d = tries_inc;
            entry_d = '0;
            len_d   = '0;
            if (a_new == AW'(DIGITS))            phase_d = StWin;
            else if (tries_inc == TW'(MAX_TRIES)) phase_d = StLose;
            else                                  phase_d = StGuess;
          end else begin
            acc_a_d = a_new;
            acc_b_d = b_new;
            if (sj_q == IW'(DIGITS - 1)) begin
              sj_d = '0;
              gi_d = gi_q + IW'(1);
            end else begin
              sj_d = sj_q + IW'(1);
            end
          end
        end
        StWin, StLose: rej_d = key_valid;
        default:       phase_d = StSet;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= StSet;
      entry_q  <= '0;
      len_q    <= '0;
      secret_q <= '0;
      guess_q  <= '0;
      acc_a_q  <= '0;
      acc_b_q  <= '0;
      gi_q     <= '0;
      sj_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      tries_q  <= '0;
      rv_q     <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      entry_q  <= entry_d;
      len_q    <= len_d;
      secret_q <= secret_d;
      guess_q  <= guess_d;
      acc_a_q  <= acc_a_d;
      acc_b_q  <= acc_b_d;
      gi_q     <= gi_d;
      sj_q     <= sj_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tries_q  <= tries_d;
      rv_q     <= rv_d;
      rej_q    <= rej_d;
    end
  end

  assign entry        = entry_q;
  assign entry_len    = len_q;
  assign phase        = phase_q;
  assign a_cnt        = a_q;
  assign b_cnt        = b_q;
  assign result_valid = rv_q;
  assign tries        = tries_q;
  assign win          = phase_q == StWin;
  assign lose         = phase_q == StLose;
  assign secret_out   = (phase_q == StWin || phase_q == StLose) ? secret_q : '0;
  assign key_reject   = rej_q;

endmodule

// File: tb/tb_guess_engine.sv
// Bench for guess_engine: directed game scenarios plus random key streams against a digit-list model.
`timescale 1ns/1ps
module tb_guess_engine;
  localparam int D  = 4;
  localparam int MT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic [15:0] entry, secret_out;
  logic [2:0]  entry_len, phase, a_cnt, b_cnt;
  logic [1:0]  tries;
  logic        result_valid, win, lose, key_reject;

  guess_engine #(.DIGITS(D), .MAX_TRIES(MT)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .entry(entry), .entry_len(entry_len), .phase(phase), .a_cnt(a_cnt), .b_cnt(b_cnt),
    .result_valid(result_valid), .tries(tries), .win(win), .lose(lose),
    .secret_out(secret_out), .key_reject(key_reject)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: entry as a list of digits (oldest first); secret indexed by nibble position.
  int m_phase;
  int m_dig[$];
  int m_sec[D];
  int m_tries, m_a, m_b;
  int p_a, p_b, p_tries, p_phase;

  function automatic void m_clear();
    m_phase = 0; m_dig.delete(); m_tries = 0; m_a = 0; m_b = 0;
    for (int n = 0; n < D; n++) m_sec[n] = 0;
  endfunction

  function automatic int m_nib(int n);
    return m_dig[m_dig.size() - 1 - n];
  endfunction

  function automatic logic [15:0] m_entry();
    logic [15:0] e = '0;
    for (int k = 0; k < m_dig.size(); k++) e = e | (16'(m_dig[k]) << (4 * (m_dig.size() - 1 - k)));
    return e;
  endfunction

  function automatic logic [15:0] m_secret_out();
    logic [15:0] s = '0;
    if (m_phase == 3 || m_phase == 4)
      for (int n = 0; n < D; n++) s = s | (16'(m_sec[n]) << (4 * n));
    return s;
  endfunction

  // Applies one key; returns whether it should be rejected.
  function automatic bit m_key(int code);
    int common;
    if (code == 12) begin m_clear(); return 1'b0; end
    if (m_phase == 2) return 1'b1;
    if (m_phase >= 3) begin
      if (code == 11) begin m_clear(); return 1'b0; end
      return 1'b1;
    end
    if (code <= 9) begin
      if (m_dig.size() == D) return 1'b1;
      foreach (m_dig[k]) if (m_dig[k] == code) return 1'b1;
      m_dig.push_back(code);
      return 1'b0;
    end
    if (code == 10) begin
      if (m_dig.size() == 0) return 1'b1;
      void'(m_dig.pop_back());
      return 1'b0;
    end
    if (code != 11 || m_dig.size() != D) return 1'b1;
    if (m_phase == 0) begin
      for (int n = 0; n < D; n++) m_sec[n] = m_nib(n);
      m_dig.delete(); m_tries = 0; m_a = 0; m_b = 0; m_phase = 1;
    end else begin
      p_a = 0; common = 0;
      for (int n = 0; n < D; n++) begin
        if (m_nib(n) == m_sec[n]) p_a++;
        for (int k = 0; k < D; k++) if (m_nib(n) == m_sec[k]) common++;
      end
      p_b     = common - p_a;
      p_tries = (m_tries < MT) ? m_tries + 1 : MT;
      p_phase = (p_a == D) ? 3 : (p_tries == MT) ? 4 : 1;
      m_phase = 2;
    end
    return 1'b0;
  endfunction

  task automatic press(input int code, output bit rej);
    @(negedge clk); key_valid = 1'b1; key_code = 4'(code);
    @(negedge clk); key_valid = 1'b0;
    rej = key_reject;
  endtask

  task automatic type_num(input logic [15:0] val);
    bit r;
    for (int k = D - 1; k >= 0; k--) press(int'(val[4*k +: 4]), r);
  endtask

  task automatic set_secret(input logic [15:0] val);
    bit r;
    press(12, r); type_num(val); press(11, r);
  endtask

  // Counts SCORE cycles until result_valid, bounded.
  task automatic wait_result(output int n, output bit got);
    n = 0; got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (result_valid) begin got = 1'b1; break; end
      if (phase == 3'd2) n++;
      @(negedge clk);
    end
  endtask

  task automatic score_guess(input logic [15:0] val, output int n, output bit got);
    bit r;
    type_num(val); press(11, r); wait_result(n, got);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (phase !== 3'd0) begin bad++; $display("FAIL reset_phase got=%0d want=0", phase); end
    total++; if (entry !== 16'h0 || entry_len !== 3'd0) begin bad++; $display("FAIL reset_entry got=%h/%0d want=0/0", entry, entry_len); end
    total++; if (a_cnt !== 3'd0 || b_cnt !== 3'd0 || tries !== 2'd0) begin bad++; $display("FAIL reset_counts got a=%0d b=%0d t=%0d want 0", a_cnt, b_cnt, tries); end
    total++; if ({result_valid, key_reject, win, lose} !== 4'b0 || secret_out !== 16'h0) begin bad++; $display("FAIL reset_flags got=%b so=%h want=0", {result_valid, key_reject, win, lose}, secret_out); end
    rst = 1'b0;
  endtask

  task automatic test_secret_entry();
    bit r;
    press(12, r); press(1, r); press(2, r); press(3, r);
    press(3, r);
    total++; if (r !== 1'b1) begin bad++; $display("FAIL dup_reject got=%b want=1", r); end
    press(4, r);
    total++; if (entry !== 16'h1234 || entry_len !== 3'd4) begin bad++; $display("FAIL secret_entry got=%h/%0d want=1234/4", entry, entry_len); end
    press(11, r);
    total++; if (r !== 1'b0 || phase !== 3'd1 || entry_len !== 3'd0 || entry !== 16'h0) begin bad++; $display("FAIL secret_enter got rej=%b ph=%0d len=%0d want 0/1/0", r, phase, entry_len); end
  endtask

  task automatic test_scoring();
    int n; bit got;
    score_guess(16'h1243, n, got);
    total++; if (n != 16 || !got) begin bad++; $display("FAIL score_latency got=%0d cycles rv=%b want=16/1", n, got); end
    total++; if (a_cnt !== 3'd2 || b_cnt !== 3'd2 || tries !== 2'd1 || phase !== 3'd1) begin bad++; $display("FAIL score_1243 got a=%0d b=%0d t=%0d ph=%0d want 2/2/1/1", a_cnt, b_cnt, tries, phase); end
    @(negedge clk);
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL rv_pulse got=%b want=0", result_valid); end
  endtask

  task automatic test_win();
    int n; bit got, r;
    set_secret(16'h1234);
    score_guess(16'h1234, n, got);
    total++; if (!got || a_cnt !== 3'd4 || b_cnt !== 3'd0 || phase !== 3'd3) begin bad++; $display("FAIL win_score got a=%0d b=%0d ph=%0d want 4/0/3", a_cnt, b_cnt, phase); end
    total++; if (win !== 1'b1 || lose !== 1'b0 || secret_out !== 16'h1234) begin bad++; $display("FAIL win_flags got w=%b l=%b so=%h want 1/0/1234", win, lose, secret_out); end
    press(5, r);
    total++; if (r !== 1'b1 || phase !== 3'd3) begin bad++; $display("FAIL win_digit got rej=%b ph=%0d want 1/3", r, phase); end
    press(11, r);
    total++; if (r !== 1'b0 || phase !== 3'd0 || secret_out !== 16'h0 || tries !== 2'd0) begin bad++; $display("FAIL win_enter got rej=%b ph=%0d so=%h t=%0d want 0/0/0/0", r, phase, secret_out, tries); end
  endtask

  task automatic test_lose();
    int n; bit got, r;
    set_secret(16'h1234);
    score_guess(16'h5678, n, got);
    total++; if (!got || a_cnt !== 3'd0 || b_cnt !== 3'd0 || phase !== 3'd1 || tries !== 2'd1) begin bad++; $display("FAIL lose_g1 got a=%0d b=%0d ph=%0d t=%0d want 0/0/1/1", a_cnt, b_cnt, phase, tries); end
    score_guess(16'h5679, n, got);
    total++; if (!got || phase !== 3'd1 || tries !== 2'd2) begin bad++; $display("FAIL lose_g2 got ph=%0d t=%0d want 1/2", phase, tries); end
    score_guess(16'h5670, n, got);
    total++; if (!got || phase !== 3'd4 || tries !== 2'd3 || lose !== 1'b1 || win !== 1'b0 || secret_out !== 16'h1234) begin bad++; $display("FAIL lose_final got ph=%0d t=%0d l=%b so=%h want 4/3/1/1234", phase, tries, lose, secret_out); end
    press(3, r);
    total++; if (r !== 1'b1) begin bad++; $display("FAIL lose_digit got=%b want=1", r); end
    set_secret(16'h1234);
    score_guess(16'h5678, n, got);
    score_guess(16'h4321, n, got);
    total++; if (a_cnt !== 3'd0 || b_cnt !== 3'd4) begin bad++; $display("FAIL score_4321 got a=%0d b=%0d want 0/4", a_cnt, b_cnt); end
    score_guess(16'h1234, n, got);
    total++; if (!got || phase !== 3'd3 || tries !== 2'd3 || win !== 1'b1) begin bad++; $display("FAIL last_try_win got ph=%0d t=%0d w=%b want 3/3/1", phase, tries, win); end
  endtask

  task automatic test_edit_edges();
    bit r;
    press(12, r);
    press(10, r);
    total++; if (r !== 1'b1) begin bad++; $display("FAIL bksp_empty got=%b want=1", r); end
    press(9, r); press(8, r); press(10, r);
    total++; if (r !== 1'b0 || entry !== 16'h0009 || entry_len !== 3'd1) begin bad++; $display("FAIL bksp got=%h/%0d want 0009/1", entry, entry_len); end
    press(7, r); press(6, r); press(11, r);
    total++; if (r !== 1'b1 || phase !== 3'd0) begin bad++; $display("FAIL short_enter got rej=%b ph=%0d want 1/0", r, phase); end
    press(0, r);
    total++; if (r !== 1'b0 || entry !== 16'h9760) begin bad++; $display("FAIL zero_digit got rej=%b e=%h want 0/9760", r, entry); end
    press(4, r);
    total++; if (r !== 1'b1 || entry !== 16'h9760 || entry_len !== 3'd4) begin bad++; $display("FAIL full_digit got rej=%b e=%h want 1/9760", r, entry); end
    press(14, r);
    total++; if (r !== 1'b1) begin bad++; $display("FAIL unused_code got=%b want=1", r); end
  endtask

  task automatic test_back_to_back();
    bit r0, r1, r2; bit r;
    press(12, r);
    @(negedge clk); key_valid = 1'b1; key_code = 4'd1;
    @(negedge clk); key_code = 4'd1; r0 = key_reject;
    @(negedge clk); key_code = 4'd2; r1 = key_reject;
    @(negedge clk); key_valid = 1'b0; r2 = key_reject;
    total++; if ({r0, r1, r2} !== 3'b010) begin bad++; $display("FAIL b2b_reject got=%b want=010", {r0, r1, r2}); end
    total++; if (entry !== 16'h0012 || entry_len !== 3'd2) begin bad++; $display("FAIL b2b_entry got=%h/%0d want 0012/2", entry, entry_len); end
  endtask

  task automatic test_abort(input bit use_rst);
    int n, rvs; bit got, r;
    set_secret(16'h1234);
    score_guess(16'h1243, n, got);
    type_num(16'h5678); press(11, r);
    repeat (4) @(negedge clk);
    if (use_rst) begin
      rst = 1'b1; #1;
    end else begin
      key_valid = 1'b1; key_code = 4'd12; @(negedge clk); key_valid = 1'b0;
    end
    total++; if (phase !== 3'd0 || tries !== 2'd0 || a_cnt !== 3'd0 || b_cnt !== 3'd0 || entry !== 16'h0 || entry_len !== 3'd0 || key_reject !== 1'b0)
      begin bad++; $display("FAIL abort_state rst=%b got ph=%0d t=%0d a=%0d b=%0d e=%h rej=%b want all 0", use_rst, phase, tries, a_cnt, b_cnt, entry, key_reject); end
    if (use_rst) begin @(negedge clk); rst = 1'b0; end
    rvs = 0;
    for (int c = 0; c < 25; c++) begin if (result_valid) rvs++; @(negedge clk); end
    total++; if (rvs != 0 || phase !== 3'd0) begin bad++; $display("FAIL abort_quiet rst=%b got rv=%0d ph=%0d want 0/0", use_rst, rvs, phase); end
  endtask

  task automatic test_random();
    int plan[$]; int code, n; bit er, r, got;
    m_clear(); press(12, r);
    for (int s = 0; s < 1200; s++) begin
      if (plan.size() == 0 && m_phase == 1 && m_dig.size() == 0 && $urandom_range(0, 3) == 0) begin
        for (int k = D - 1; k >= 0; k--) plan.push_back(m_sec[k]);
        plan.push_back(11);
      end
      if (plan.size() != 0) code = plan.pop_front();
      else begin
        code = $urandom_range(0, 15);
        if (code == 12 && $urandom_range(0, 7) != 0) code = 11;
      end
      er = m_key(code);
      press(code, r);
      total++; if (r !== er || entry !== m_entry() || entry_len !== 3'(m_dig.size()) || phase !== 3'(m_phase))
        begin bad++; $display("FAIL rand_key%0d code=%0d got rej=%b e=%h len=%0d ph=%0d want %b/%h/%0d/%0d", s, code, r, entry, entry_len, phase, er, m_entry(), m_dig.size(), m_phase); end
      if (m_phase == 2) begin
        wait_result(n, got);
        m_a = p_a; m_b = p_b; m_tries = p_tries; m_phase = p_phase; m_dig.delete();
        total++; if (n != D * D || !got || a_cnt !== 3'(m_a) || b_cnt !== 3'(m_b) || tries !== 2'(m_tries) || phase !== 3'(m_phase))
          begin bad++; $display("FAIL rand_score%0d got n=%0d rv=%b a=%0d b=%0d t=%0d ph=%0d want 16/1/%0d/%0d/%0d/%0d", s, n, got, a_cnt, b_cnt, tries, phase, m_a, m_b, m_tries, m_phase); end
        total++; if (win !== (m_phase == 3) || lose !== (m_phase == 4) || secret_out !== m_secret_out() || entry !== 16'h0)
          begin bad++; $display("FAIL rand_end%0d got w=%b l=%b so=%h e=%h want so=%h", s, win, lose, secret_out, entry, m_secret_out()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_secret_entry();
    test_scoring();
    test_win();
    test_lose();
    test_edit_edges();
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
